dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Shares the single data-memory port between the pipeline MEM stage (CPU requester) and the debug unit, which performs burst memory dumps.
- Sits between the MEM stage and the data memory array. The memory array is modified to expose a raw port: synchronous write with byte enables, asynchronous read.
- The CPU has priority. A starvation guard guarantees that a debug dump makes forward progress, stalling the pipeline for one cycle when needed.

Parameters:
- ADDR_W, 8, word-index width of data memory (256 words).
- DATA_W, 32, data word width.
- CNT_W, 9, width of the burst word count (up to 256 words).
- STARVE_LIMIT, 4, consecutive lost debug read slots before debug is forced a grant.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cpu_req  in  1  MEM stage accesses memory this cycle (mem_read or mem_write)
- cpu_we  in  1  1 = store, 0 = load
- cpu_be  in  4  byte enables for stores (SB/SH/SW lanes already decoded)
- cpu_addr  in  32  byte address; word index = cpu_addr[ADDR_W+1:2]
- cpu_wdata  in  DATA_W  store data, lane-aligned
- cpu_rdata  out  DATA_W  raw word read, combinational from mem_rdata
- cpu_stall  out  1  pipeline must hold MEM and earlier stages this cycle
- dbg_start  in  1  one-cycle pulse that starts a dump
- dbg_base  in  ADDR_W  first word index of the dump
- dbg_count  in  CNT_W  number of words to dump
- dbg_busy  out  1  dump in progress
- dbg_data  out  DATA_W  registered dump word
- dbg_data_valid  out  1  dbg_data is valid
- dbg_data_ready  in  1  consumer accepts dbg_data
- dbg_done  out  1  one-cycle pulse after the last word is accepted
- mem_we  out  1  memory write enable
- mem_be  out  4  memory byte enables
- mem_addr  out  ADDR_W  memory word index
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  asynchronous read data from memory

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE; index, starvation counter and dbg_data register clear.
  - Outputs: dbg_busy=0, dbg_data_valid=0, dbg_done=0, dbg_data=0, cpu_stall=0, mem_we=0.
  - Reset during a dump aborts it. No dbg_done is issued.
- States: IDLE, DUMP_RD, DUMP_HOLD, DONE.
- Memory port mux (combinational):
  - When the CPU is granted: mem_* = cpu_* and mem_we = cpu_req & cpu_we.
  - When debug is granted: mem_addr = dbg_base + idx (mod 2^ADDR_W), mem_we=0, mem_be=4'hF.
- IDLE:
  - The CPU is always granted.
  - dbg_start with dbg_count != 0 latches base and count, clears idx, and moves to DUMP_RD.
  - dbg_start with dbg_count = 0 is ignored: no busy, no done.
- DUMP_RD:
  - If cpu_req=0, debug is granted. mem_rdata is captured into dbg_data, dbg_data_valid is set next cycle, the starvation counter clears, and the state moves to DUMP_HOLD.
  - If cpu_req=1 and the starvation counter < STARVE_LIMIT, the CPU is granted and the counter increments.
  - If cpu_req=1 and the counter = STARVE_LIMIT, debug is granted and cpu_stall=1 for that cycle only. The CPU is not granted and no CPU write occurs.
- DUMP_HOLD:
  - The CPU is always granted.
  - dbg_data_valid stays high and dbg_data stays stable until dbg_data_ready=1.
  - On accept, valid drops and idx increments. If idx+1 == count, go to DONE; otherwise go to DUMP_RD.
- DONE:
  - dbg_done=1 for one cycle and the CPU is granted. The state then returns to IDLE.
- dbg_busy = 1 in DUMP_RD, DUMP_HOLD and DONE.
- dbg_start while busy is ignored.
- cpu_stall is only ever asserted in DUMP_RD under the forced grant. It never asserts in two consecutive cycles.
- Address wrap: base + idx wraps modulo 2^ADDR_W. Base 0xFE with count 4 reads words 0xFE, 0xFF, 0x00, 0x01.
- Latency: at least 2 cycles from dbg_start to the first dbg_data_valid (IDLE→DUMP_RD, DUMP_RD→DUMP_HOLD).
- Coherency: a CPU store to a word already captured into dbg_data does not alter dbg_data.

Decomposition:
- Shared package mips_pkg.vh gains the state encodings (DMEM_ARB_IDLE, DMEM_ARB_DUMP_RD, DMEM_ARB_DUMP_HOLD, DMEM_ARB_DONE) and the byte-enable constant BE_WORD=4'hF.
- One natural sub-module: dmem_dump_fsm, containing the state register, idx, starvation counter and dbg_data register.
- The top level keeps only the grant and port mux.

Test Plan:
- CPU pass-through: IDLE, cpu_req=1, cpu_we=1, be=4'b0010, addr=0x14, wdata=0x0000AB00 → mem_we=1, mem_addr=5, mem_be=4'b0010, cpu_stall=0.
- Basic dump: preload words 0x10–0x12 with 0xA, 0xB, 0xC; dbg_start, base=0x10, count=3, ready held 1 → dbg_data 0xA, 0xB, 0xC each with a valid pulse, then dbg_done one cycle later, then dbg_busy=0.
- Backpressure and wrap: base=0xFF, count=2, ready=0 for 5 cycles → valid stays high with word 0xFF stable; then ready=1 → next word comes from index 0x00.
- Starvation: dump active, cpu_req=1 continuously → debug is denied 4 slots, then cpu_stall=1 for exactly one cycle with mem_addr=base; the pattern repeats per word.
- Edge commands: dbg_start with count=0 → no busy, no done; dbg_start mid-dump → ignored, original burst completes.
- Reset mid-dump: assert reset in DUMP_HOLD → dbg_data_valid=0, dbg_busy=0, cpu_stall=0 immediately; no dbg_done; a new dump after reset works.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Dump FSM state encodings and the full-word byte-enable mask.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    DMEM_ARB_IDLE      = 2'd0,
    DMEM_ARB_DUMP_RD   = 2'd1,
    DMEM_ARB_DUMP_HOLD = 2'd2,
    DMEM_ARB_DONE      = 2'd3
  } dmem_arb_state_t;

  localparam logic [3:0] BE_WORD = 4'hF;

endpackage

// File: rtl/dmem_dump_fsm.sv
// Debug burst-dump sequencer: state, word index, starvation
// counter and the registered dump word.
module dmem_dump_fsm
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 32,
  parameter int CNT_W        = 9,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              dbg_start,
  input  logic [ADDR_W-1:0] dbg_base,
  input  logic [CNT_W-1:0]  dbg_count,
  input  logic              dbg_data_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              dbg_grant,
  output logic              dbg_stall,
  output logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_busy,
  output logic [DATA_W-1:0] dbg_data,
  output logic              dbg_data_valid,
  output logic              dbg_done
);

  localparam int SW = $clog2(STARVE_LIMIT + 2);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  dmem_arb_state_t   state, state_nx;
  logic [ADDR_W-1:0] base_q, base_nx;
  logic [CNT_W-1:0]  count_q, count_nx;
  logic [CNT_W-1:0]  idx_q, idx_nx;
  logic [SW-1:0]     starve_q, starve_nx;
  logic [DATA_W-1:0] data_q;
  logic              capture;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= DMEM_ARB_IDLE;
      base_q   <= '0;
      count_q  <= '0;
      idx_q    <= '0;
      starve_q <= '0;
      data_q   <= '0;
    end else begin
      state    <= state_nx;
      base_q   <= base_nx;
      count_q  <= count_nx;
      idx_q    <= idx_nx;
      starve_q <= starve_nx;
      if (capture)
        data_q <= mem_rdata;
    end
  end

  always_comb begin
    state_nx  = state;
    base_nx   = base_q;
    count_nx  = count_q;
    idx_nx    = idx_q;
    starve_nx = starve_q;
    dbg_grant = 1'b0;
    dbg_stall = 1'b0;
    capture   = 1'b0;
    unique case (state)
      DMEM_ARB_IDLE: begin
        if (dbg_start && (dbg_count != '0)) begin
          base_nx   = dbg_base;
          count_nx  = dbg_count;
          idx_nx    = '0;
          starve_nx = '0;
          state_nx  = DMEM_ARB_DUMP_RD;
        end
      end
      DMEM_ARB_DUMP_RD: begin
        if (!cpu_req || (starve_q == LIMIT)) begin
          // Forced slot: pipeline holds so the CPU access replays later.
          dbg_grant = 1'b1;
          dbg_stall = cpu_req;
          capture   = 1'b1;
          starve_nx = '0;
          state_nx  = DMEM_ARB_DUMP_HOLD;
        end else begin
          starve_nx = starve_q + 1'b1;
        end
      end
      DMEM_ARB_DUMP_HOLD: begin
        if (dbg_data_ready) begin
          idx_nx = idx_q + 1'b1;
          if (idx_nx == count_q)
            state_nx = DMEM_ARB_DONE;
          else
            state_nx = DMEM_ARB_DUMP_RD;
        end
      end
      DMEM_ARB_DONE: begin
        state_nx = DMEM_ARB_IDLE;
      end
      default: begin
        state_nx = DMEM_ARB_IDLE;
      end
    endcase
  end

  assign dbg_addr       = base_q + idx_q[ADDR_W-1:0];
  assign dbg_busy       = (state != DMEM_ARB_IDLE);
  assign dbg_data       = data_q;
  assign dbg_data_valid = (state == DMEM_ARB_DUMP_HOLD);
  assign dbg_done       = (state == DMEM_ARB_DONE);

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter between the MEM stage and the debug
// dump engine; CPU has priority with a bounded starvation guard.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 32,
  parameter int CNT_W        = 9,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [3:0]        cpu_be,
  input  logic [31:0]       cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_start,
  input  logic [ADDR_W-1:0] dbg_base,
  input  logic [CNT_W-1:0]  dbg_count,
  output logic              dbg_busy,
  output logic [DATA_W-1:0] dbg_data,
  output logic              dbg_data_valid,
  input  logic              dbg_data_ready,
  output logic              dbg_done,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic              dbg_grant;
  logic              dbg_stall;
  logic [ADDR_W-1:0] dbg_addr;
  logic [ADDR_W-1:0] cpu_word;
  logic              unused_addr;

  assign cpu_word    = cpu_addr[ADDR_W+1:2];
  assign unused_addr = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0]};

  dmem_dump_fsm #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .CNT_W        (CNT_W),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_fsm (
    .clk            (clk),
    .reset          (reset),
    .cpu_req        (cpu_req),
    .dbg_start      (dbg_start),
    .dbg_base       (dbg_base),
    .dbg_count      (dbg_count),
    .dbg_data_ready (dbg_data_ready),
    .mem_rdata      (mem_rdata),
    .dbg_grant      (dbg_grant),
    .dbg_stall      (dbg_stall),
    .dbg_addr       (dbg_addr),
    .dbg_busy       (dbg_busy),
    .dbg_data       (dbg_data),
    .dbg_data_valid (dbg_data_valid),
    .dbg_done       (dbg_done)
  );

  always_comb begin
    mem_we    = 1'b0;
    mem_be    = cpu_be;
    mem_addr  = cpu_word;
    mem_wdata = cpu_wdata;
    unique case (1'b1)
      dbg_grant: begin
        mem_be   = BE_WORD;
        mem_addr = dbg_addr;
      end
      default: begin
        mem_we = cpu_req & cpu_we;
      end
    endcase
  end

  assign cpu_rdata = mem_rdata;
  assign cpu_stall = dbg_stall;

endmodule
